router_demux4: RTL

ROUTER_DEMUX4 -- requirements
Module: router_demux4

---
 rtl/router_pkg.sv | 37 +++
 rtl/router_fifo.sv | 72 +++++++
 rtl/router_demux4.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared widths, input FSM states and skid-FIFO entry layout
//                for the router demux.
//  Revision    : 1.0  initial release
// ============================================================================
package router_pkg;

   localparam int BEAT_W = 64;
   localparam int DEST_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FRAME = 2'd1,
      ST_DROP  = 2'd2
   } state_t;

   typedef struct packed {
      logic [BEAT_W-1:0] data;
      logic              hdr;
      logic              pld;
      logic              sof;
      logic              eof;
      logic [DEST_W-1:0] dest;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   // A destination is legal when it names an existing port other than ours.
   function automatic logic dest_ok(input logic [DEST_W-1:0] field,
                                    input int num_ports, input int port_no);
      return (int'(field) < num_ports) && (int'(field) != port_no);
   endfunction

endpackage
`default_nettype wire

// File: rtl/router_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : router_fifo
//  Description : Synchronous first-word-fall-through skid FIFO with a
//                registered occupancy count. A push is taken while full if a
//                pop happens on the same edge.
//  Revision    : 1.0  initial release
// ============================================================================
module router_fifo #(
   parameter int WIDTH = 76,
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_wr;
   logic             w_rd;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rd_ptr];

   assign w_rd = i_pop && !o_empty;
   assign w_wr = i_push && (!o_full || w_rd);

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Storage array, no reset needed since occupancy gates every read.
   always_ff @(posedge CLK) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (w_wr && !w_rd) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_wr && w_rd) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/router_demux4.sv
`default_nettype none
// ============================================================================
//  Module      : router_demux4
//  Description : Ingress frame filter and broadcast feeder. Validates the
//                destination in the SOF header, drops or truncates malformed
//                frames, buffers beats in a skid FIFO and drives registered
//                egress beats to all muxes under their backpressure.
//  Revision    : 1.0  initial release
// ============================================================================
module router_demux4
   import router_pkg::*;
#(
   parameter int NumPorts  = 4,
   parameter int PortNo    = 1,
   parameter int FifoDepth = 8
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [BEAT_W-1:0]   I_D,
   input  logic                I_HDR_VALID,
   input  logic                I_PLD_VALID,
   input  logic                I_SOF,
   input  logic                I_EOF,
   output logic                I_BP,
   output logic [BEAT_W-1:0]   D,
   output logic [DEST_W-1:0]   DEST,
   output logic                DEST_VALID,
   output logic                D_HDR_VALID,
   output logic                D_PLD_VALID,
   output logic                D_SOF,
   output logic                D_EOF,
   input  logic [NumPorts-1:0] D_BP,
   output logic [15:0]         FRM_CNT,
   output logic [15:0]         DROP_CNT,
   output logic [7:0]          ERR_CNT
);

   localparam int CNT_W = $clog2(FifoDepth + 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DEST_W-1:0]   r_frm_dest;
   logic [DEST_W-1:0]   w_frm_dest_nxt;
   entry_t              w_wentry;
   entry_t              w_rentry;
   logic [ENTRY_W-1:0]  w_rdata;
   logic                w_beat;
   logic                w_room;
   logic                w_push;
   logic                w_pop;
   logic                w_full;
   logic                w_empty;
   logic                w_err;
   logic                w_drop;
   logic [CNT_W-1:0]    w_count;
   logic [CNT_W-1:0]    w_count_nxt;

   logic                r_ibp;
   logic [BEAT_W-1:0]   r_d;
   logic [DEST_W-1:0]   r_dest;
   logic                r_dest_valid;
   logic                r_d_hdr;
   logic                r_d_pld;
   logic                r_d_sof;
   logic                r_d_eof;
   logic [15:0]         r_frm_cnt;
   logic [15:0]         r_drop_cnt;
   logic [7:0]          r_err_cnt;

   assign w_beat   = I_HDR_VALID | I_PLD_VALID;
   // A new SOF waits until the previous frame's DEST_VALID has dropped, so
   // downstream always sees DEST_VALID low between frames.
   assign w_pop    = !w_empty && !(|D_BP) && !(w_rentry.sof && r_dest_valid);
   assign w_room   = !w_full || w_pop;
   assign w_rentry = entry_t'(w_rdata);
   assign w_count_nxt = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

   router_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FifoDepth),
      .CNT_W (CNT_W)
   ) u_fifo (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .i_push  (w_push),
      .i_wdata (w_wentry),
      .i_pop   (w_pop),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Input FSM state and latched frame destination.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state    <= ST_IDLE;
         r_frm_dest <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_frm_dest <= w_frm_dest_nxt;
      end
   end

   // Next state, FIFO write and error/drop events for the current beat.
   always_comb begin
      w_state_nxt    = r_state;
      w_frm_dest_nxt = r_frm_dest;
      w_push         = 1'b0;
      w_err          = 1'b0;
      w_drop         = 1'b0;
      w_wentry.data  = I_D;
      w_wentry.hdr   = I_HDR_VALID;
      w_wentry.pld   = I_PLD_VALID;
      w_wentry.sof   = I_SOF;
      w_wentry.eof   = I_EOF;
      w_wentry.dest  = r_frm_dest;
      if (w_beat) begin
         if (!w_room) begin
            w_err = 1'b1;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (I_SOF && I_HDR_VALID) begin
                     if (dest_ok(I_D[DEST_W-1:0], NumPorts, PortNo)) begin
                        w_frm_dest_nxt = I_D[DEST_W-1:0];
                        w_wentry.dest  = I_D[DEST_W-1:0];
                        w_push         = 1'b1;
                        w_state_nxt    = I_EOF ? ST_IDLE : ST_FRAME;
                     end else begin
                        w_drop      = 1'b1;
                        w_state_nxt = I_EOF ? ST_IDLE : ST_DROP;
                     end
                  end else begin
                     w_err = 1'b1;
                  end
               end
               ST_FRAME: begin
                  w_push = 1'b1;
                  if (I_SOF) begin
                     w_wentry.sof = 1'b0;
                     w_wentry.eof = 1'b1;
                     w_err        = 1'b1;
                     w_state_nxt  = I_EOF ? ST_IDLE : ST_DROP;
                  end else if (I_EOF) begin
                     w_state_nxt = ST_IDLE;
                  end
               end
               ST_DROP: begin
                  if (I_EOF) w_state_nxt = ST_IDLE;
               end
               default: w_state_nxt = ST_IDLE;
            endcase
         end
      end
   end

   // Egress register: popped beat, destination tracking and backpressure.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_ibp        <= 1'b0;
         r_d          <= '0;
         r_dest       <= '0;
         r_dest_valid <= 1'b0;
         r_d_hdr      <= 1'b0;
         r_d_pld      <= 1'b0;
         r_d_sof      <= 1'b0;
         r_d_eof      <= 1'b0;
      end else begin
         r_ibp   <= (w_count_nxt >= CNT_W'(FifoDepth - 3));
         r_d_hdr <= 1'b0;
         r_d_pld <= 1'b0;
         r_d_sof <= 1'b0;
         r_d_eof <= 1'b0;
         if (r_d_eof) r_dest_valid <= 1'b0;
         if (w_pop) begin
            r_d     <= w_rentry.data;
            r_d_hdr <= w_rentry.hdr;
            r_d_pld <= w_rentry.pld;
            r_d_sof <= w_rentry.sof;
            r_d_eof <= w_rentry.eof;
            if (w_rentry.sof) begin
               r_dest       <= w_rentry.dest;
               r_dest_valid <= 1'b1;
            end
         end
      end
   end

   // Statistics: frames and drops wrap, errors saturate.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_frm_cnt  <= '0;
         r_drop_cnt <= '0;
         r_err_cnt  <= '0;
      end else begin
         if (w_pop && w_rentry.eof) r_frm_cnt <= r_frm_cnt + 16'd1;
         if (w_drop) r_drop_cnt <= r_drop_cnt + 16'd1;
         if (w_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign I_BP        = r_ibp;
   assign D           = r_d;
   assign DEST        = r_dest;
   assign DEST_VALID  = r_dest_valid;
   assign D_HDR_VALID = r_d_hdr;
   assign D_PLD_VALID = r_d_pld;
   assign D_SOF       = r_d_sof;
   assign D_EOF       = r_d_eof;
   assign FRM_CNT     = r_frm_cnt;
   assign DROP_CNT    = r_drop_cnt;
   assign ERR_CNT     = r_err_cnt;

endmodule
`default_nettype wire
